// File: rtl/sblk_row_inst_sched.sv
// ---------------------------------------------------------------------------
// sblk_row_inst_sched
//   Instruction scheduler in front of the superblock row array. It takes one
//   instruction stream (valid/ready) carrying a row mask and a barrier flag.
//   Each instruction is held until its target rows are idle, or until all rows
//   are idle for a barrier. It is then broadcast with a one-cycle per-row
//   strobe. Row busy is the row's own status OR'd with a launch-pending flag.
//   The flag covers the gap between the strobe and the row reporting busy.
//   If a row never starts, a per-row timer ends the pending flag and latches
//   an error.
//
// Ports
//   clk_l        in   slow-domain clock, posedge
//   rst_n        in   asynchronous active-low reset
//   s_inst_vld   in   instruction valid
//   s_inst_rdy   out  scheduler can accept (IDLE), combinational
//   s_inst_data  in   instruction payload
//   s_inst_mask  in   target rows, bit i selects row i
//   s_inst_sync  in   barrier: issue only when all rows are idle
//   inst_data    out  per-row payload, row i at [i*WID_INST +: WID_INST]
//   inst_en      out  one-cycle issue strobe per row
//   status_sblk  in   row executing (already synchronous to clk_l)
//   row_busy     out  status_sblk | launch_pend, combinational
//   all_idle     out  no row busy and scheduler IDLE, combinational
//   err_timeout  out  sticky: row did not go busy within LAUNCH_TO cycles
//   err_mask0    out  sticky: an instruction with an empty mask was accepted
//   issue_cnt    out  issued-instruction count, wraps
// ---------------------------------------------------------------------------
module sblk_row_inst_sched #(
    parameter int unsigned N_ROW     = 3,
    parameter int unsigned WID_INST  = 14,
    parameter int unsigned LAUNCH_TO = 15,
    parameter int unsigned WID_CNT   = 16
) (
    input  logic                      clk_l,
    input  logic                      rst_n,
    input  logic                      s_inst_vld,
    output logic                      s_inst_rdy,
    input  logic [WID_INST-1:0]       s_inst_data,
    input  logic [N_ROW-1:0]          s_inst_mask,
    input  logic                      s_inst_sync,
    output logic [WID_INST*N_ROW-1:0] inst_data,
    output logic [N_ROW-1:0]          inst_en,
    input  logic [N_ROW-1:0]          status_sblk,
    output logic [N_ROW-1:0]          row_busy,
    output logic                      all_idle,
    output logic [N_ROW-1:0]          err_timeout,
    output logic                      err_mask0,
    output logic [WID_CNT-1:0]        issue_cnt
);

    // The timer only has to reach LAUNCH_TO-1 before the timeout fires.
    localparam int unsigned TMR_W   = (LAUNCH_TO < 2) ? 1 : $clog2(LAUNCH_TO);
    localparam int unsigned DATA_W  = WID_INST * N_ROW;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_ISSUE = 2'd2
    } state_e;

    state_e                state_q,     state_d;
    logic [WID_INST-1:0]   hdata_q,     hdata_d;
    logic [N_ROW-1:0]      hmask_q,     hmask_d;
    logic                  hsync_q,     hsync_d;
    logic [DATA_W-1:0]     inst_data_q, inst_data_d;
    logic [N_ROW-1:0]      inst_en_q,   inst_en_d;
    logic [N_ROW-1:0]      pend_q,      pend_d;
    logic [TMR_W-1:0]      tmr_q [N_ROW];
    logic [TMR_W-1:0]      tmr_d [N_ROW];
    logic [N_ROW-1:0]      err_to_q,    err_to_d;
    logic                  err_m0_q,    err_m0_d;
    logic [WID_CNT-1:0]    cnt_q,       cnt_d;

    logic                  gate;

    // Busy view used both for gating and for the caller.
    assign row_busy    = status_sblk | pend_q;
    assign s_inst_rdy  = (state_q == ST_IDLE);
    assign all_idle    = ~|row_busy && (state_q == ST_IDLE);

    assign inst_data   = inst_data_q;
    assign inst_en     = inst_en_q;
    assign err_timeout = err_to_q;
    assign err_mask0   = err_m0_q;
    assign issue_cnt   = cnt_q;

    // Barrier waits for every row; a normal instruction only for its own rows.
    assign gate = hsync_q ? ~|row_busy : ~|(row_busy & hmask_q);

    // Next-state logic: launch tracking first, then the FSM so that a new
    // issue overrides any clear on the same row.
    always_comb begin
        state_d     = state_q;
        hdata_d     = hdata_q;
        hmask_d     = hmask_q;
        hsync_d     = hsync_q;
        inst_data_d = inst_data_q;
        inst_en_d   = '0;
        pend_d      = pend_q;
        tmr_d       = tmr_q;
        err_to_d    = err_to_q;
        err_m0_d    = err_m0_q;
        cnt_d       = cnt_q;

        // A pending launch ends when the row reports busy or the timer expires.
        for (int unsigned i = 0; i < N_ROW; i++) begin
            if (pend_q[i]) begin
                if (status_sblk[i]) begin
                    pend_d[i] = 1'b0;
                    tmr_d[i]  = '0;
                end else if (tmr_q[i] == TMR_W'(LAUNCH_TO - 1)) begin
                    pend_d[i]   = 1'b0;
                    tmr_d[i]    = '0;
                    err_to_d[i] = 1'b1;
                end else begin
                    tmr_d[i] = tmr_q[i] + TMR_W'(1);
                end
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (s_inst_vld) begin
                    if (s_inst_mask == '0) begin
                        err_m0_d = 1'b1;
                    end else begin
                        hdata_d = s_inst_data;
                        hmask_d = s_inst_mask;
                        hsync_d = s_inst_sync;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                // Strobe, payload and pend all become visible in the ISSUE cycle.
                if (gate) begin
                    state_d   = ST_ISSUE;
                    inst_en_d = hmask_q;
                    pend_d    = pend_d | hmask_q;
                    cnt_d     = cnt_q + WID_CNT'(1);
                    for (int unsigned i = 0; i < N_ROW; i++) begin
                        if (hmask_q[i]) begin
                            inst_data_d[i*WID_INST +: WID_INST] = hdata_q;
                            tmr_d[i] = '0;
                        end
                    end
                end
            end
            ST_ISSUE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk_l or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            hdata_q     <= '0;
            hmask_q     <= '0;
            hsync_q     <= 1'b0;
            inst_data_q <= '0;
            inst_en_q   <= '0;
            pend_q      <= '0;
            for (int unsigned i = 0; i < N_ROW; i++) begin
                tmr_q[i] <= '0;
            end
            err_to_q    <= '0;
            err_m0_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            hdata_q     <= hdata_d;
            hmask_q     <= hmask_d;
            hsync_q     <= hsync_d;
            inst_data_q <= inst_data_d;
            inst_en_q   <= inst_en_d;
            pend_q      <= pend_d;
            for (int unsigned i = 0; i < N_ROW; i++) begin
                tmr_q[i] <= tmr_d[i];
            end
            err_to_q    <= err_to_d;
            err_m0_q    <= err_m0_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
